game_ctrl: RTL and testbench

Round sequencer for the two-player factorization game. It owns the shared 4-bit `STATE` bus that the ready/seed block watches. It takes that block's `OK`/`NUM` handoff to start a round and turns `NUM` into a target composite. It judges the 1P/2P factor answers against a time limit, keeps the score, and declares the match winner.

---
 rtl/game_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_game_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Round sequencer for the two-player factorization game: starts rounds on the
// ready block's OK edge, judges 1P/2P factor answers against a timer, keeps score.
module game_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ANS_SEC    = 9,
  parameter int RESULT_SEC = 2,
  parameter int WIN_SCORE  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic       ANS_VALID_1P,
  input  logic [3:0] ANS_1P,
  input  logic       ANS_VALID_2P,
  input  logic [3:0] ANS_2P,
  input  logic       RESTART,
  output logic [3:0] STATE,
  output logic [5:0] TARGET,
  output logic [2:0] SCORE_1P,
  output logic [2:0] SCORE_2P,
  output logic [3:0] TIME_LEFT
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RES_W  = (RESULT_SEC > 1) ? $clog2(RESULT_SEC) : 1;
  localparam logic [2:0] WIN_PTS = 3'(WIN_SCORE);

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0000,
    S_WAIT     = 4'b0001,
    S_QUESTION = 4'b0010,
    S_DRAW     = 4'b0110,
    S_GOOD     = 4'b1000,
    S_OUCH     = 4'b1001,
    S_WIN      = 4'b1010,
    S_LOSE     = 4'b1011
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          target_q, target_d;
  logic [3:0]          p_q, p_d, q_q, q_d;
  logic [2:0]          score1_q, score1_d, score2_q, score2_d;
  logic [3:0]          time_left_q, time_left_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [RES_W-1:0]    res_cnt_q, res_cnt_d;
  logic                ok_prev_q, ok_prev_d;

  logic        tick, ok_rise, num_ok, corr_1p, corr_2p;
  logic [13:0] rom_w;

  // Packs {target, p, q} for a seed; invalid seeds return zero.
  function automatic logic [13:0] target_rom(input logic [3:0] n);
    case (n)
      4'd1:    target_rom = {6'd6,  4'd2, 4'd3};
      4'd2:    target_rom = {6'd9,  4'd3, 4'd3};
      4'd3:    target_rom = {6'd10, 4'd2, 4'd5};
      4'd4:    target_rom = {6'd14, 4'd2, 4'd7};
      4'd5:    target_rom = {6'd15, 4'd3, 4'd5};
      4'd6:    target_rom = {6'd21, 4'd3, 4'd7};
      4'd7:    target_rom = {6'd22, 4'd2, 4'd11};
      4'd8:    target_rom = {6'd25, 4'd5, 4'd5};
      4'd9:    target_rom = {6'd26, 4'd2, 4'd13};
      4'd10:   target_rom = {6'd35, 4'd5, 4'd7};
      default: target_rom = '0;
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    sat_inc = (s >= WIN_PTS) ? WIN_PTS : s + 3'd1;
  endfunction

  assign rom_w   = target_rom(NUM);
  assign num_ok  = (NUM >= 4'd1) && (NUM <= 4'd10);
  assign ok_rise = OK && !ok_prev_q;
  assign tick    = (tick_cnt_q == TICK_W'(CLK_HZ - 1));
  assign corr_1p = (ANS_1P == p_q) || (ANS_1P == q_q);
  assign corr_2p = (ANS_2P == p_q) || (ANS_2P == q_q);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    p_d         = p_q;
    q_d         = q_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    time_left_d = time_left_q;
    res_cnt_d   = res_cnt_q;
    ok_prev_d   = OK;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (ok_rise && num_ok) begin
          state_d     = S_QUESTION;
          target_d    = rom_w[13:8];
          p_d         = rom_w[7:4];
          q_d         = rom_w[3:0];
          time_left_d = 4'(ANS_SEC);
        end
      end
      S_QUESTION: begin
        // Answers are checked before the timer so a strobe on the timeout tick wins.
        if (ANS_VALID_1P && ANS_VALID_2P) begin
          if (corr_1p && !corr_2p) begin
            state_d  = S_GOOD;
            score1_d = sat_inc(score1_q);
          end else if (corr_2p && !corr_1p) begin
            state_d  = S_OUCH;
            score2_d = sat_inc(score2_q);
          end else begin
            state_d = S_DRAW;
          end
        end else if (ANS_VALID_1P) begin
          if (corr_1p) begin
            state_d  = S_GOOD;
            score1_d = sat_inc(score1_q);
          end else begin
            state_d  = S_OUCH;
            score2_d = sat_inc(score2_q);
          end
        end else if (ANS_VALID_2P) begin
          if (corr_2p) begin
            state_d  = S_OUCH;
            score2_d = sat_inc(score2_q);
          end else begin
            state_d  = S_GOOD;
            score1_d = sat_inc(score1_q);
          end
        end else if (tick) begin
          if (time_left_q <= 4'd1) begin
            time_left_d = 4'd0;
            state_d     = S_DRAW;
          end else begin
            time_left_d = time_left_q - 4'd1;
          end
        end
      end
      S_DRAW, S_GOOD, S_OUCH: begin
        if (tick) begin
          if (res_cnt_q == RES_W'(RESULT_SEC - 1)) begin
            target_d = '0;
            if (score1_q == WIN_PTS)      state_d = S_WIN;
            else if (score2_q == WIN_PTS) state_d = S_LOSE;
            else                          state_d = S_WAIT;
          end else begin
            res_cnt_d = res_cnt_q + 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (RESTART) begin
          state_d  = S_WAIT;
          score1_d = '0;
          score2_d = '0;
          target_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        target_d = '0;
      end
    endcase

    // Every state starts with a fresh second and a fresh hold count.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      res_cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      p_q         <= '0;
      q_q         <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      time_left_q <= '0;
      tick_cnt_q  <= '0;
      res_cnt_q   <= '0;
      ok_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      p_q         <= p_d;
      q_q         <= q_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      time_left_q <= time_left_d;
      tick_cnt_q  <= tick_cnt_d;
      res_cnt_q   <= res_cnt_d;
      ok_prev_q   <= ok_prev_d;
    end
  end

  assign STATE     = state_q;
  assign TARGET    = target_q;
  assign SCORE_1P  = score1_q;
  assign SCORE_2P  = score2_q;
  assign TIME_LEFT = time_left_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expectations are queued as stimulus is driven
// and compared against the registered outputs after the following clock edges.
module tb_game_ctrl;

  localparam int CLK_HZ     = 4;
  localparam int ANS_SEC    = 3;
  localparam int RESULT_SEC = 2;
  localparam int WIN_SCORE  = 3;
  localparam int HOLD       = RESULT_SEC * CLK_HZ;

  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_Q = 2, ST_DRAW = 6;
  localparam int ST_GOOD = 8, ST_OUCH = 9, ST_WIN = 10, ST_LOSE = 11;
  localparam int DC = -1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       OK = 1'b0;
  logic [3:0] NUM = 4'd0;
  logic       ANS_VALID_1P = 1'b0;
  logic [3:0] ANS_1P = 4'd0;
  logic       ANS_VALID_2P = 1'b0;
  logic [3:0] ANS_2P = 4'd0;
  logic       RESTART = 1'b0;
  logic [3:0] STATE;
  logic [5:0] TARGET;
  logic [2:0] SCORE_1P, SCORE_2P;
  logic [3:0] TIME_LEFT;

  game_ctrl #(
    .CLK_HZ(CLK_HZ), .ANS_SEC(ANS_SEC), .RESULT_SEC(RESULT_SEC), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .CLK(CLK), .RST(RST), .OK(OK), .NUM(NUM),
    .ANS_VALID_1P(ANS_VALID_1P), .ANS_1P(ANS_1P),
    .ANS_VALID_2P(ANS_VALID_2P), .ANS_2P(ANS_2P),
    .RESTART(RESTART), .STATE(STATE), .TARGET(TARGET),
    .SCORE_1P(SCORE_1P), .SCORE_2P(SCORE_2P), .TIME_LEFT(TIME_LEFT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string tag;
    int    st;
    int    tgt;
    int    s1;
    int    s2;
    int    tl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   e_s1 = 0;
  int   e_s2 = 0;
  int   tgt_tab [0:10] = '{0, 6, 9, 10, 14, 15, 21, 22, 25, 26, 35};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int st, input int tgt, input int tl);
    exp_t e;
    e.tag = tag; e.st = st; e.tgt = tgt; e.s1 = e_s1; e.s2 = e_s2; e.tl = tl;
    exp_q.push_back(e);
  endtask

  // Advance n clocks, then compare every queued expectation with the outputs.
  task automatic cyc(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".state"}, 32'(STATE), e.st);
      check({e.tag, ".target"}, 32'(TARGET), e.tgt);
      check({e.tag, ".score1"}, 32'(SCORE_1P), e.s1);
      check({e.tag, ".score2"}, 32'(SCORE_2P), e.s2);
      if (e.tl != DC) check({e.tag, ".time"}, 32'(TIME_LEFT), e.tl);
    end
  endtask

  task automatic start_round(input string tag, input int num);
    OK  = 1'b1;
    NUM = 4'(num);
    push({tag, "_start"}, ST_Q, tgt_tab[num], ANS_SEC);
    cyc(1);
    OK = 1'b0;
  endtask

  task automatic answer(input string tag, input int tgt, input logic v1, input int a1,
                        input logic v2, input int a2, input int res);
    ANS_VALID_1P = v1; ANS_1P = 4'(a1);
    ANS_VALID_2P = v2; ANS_2P = 4'(a2);
    if (res == ST_GOOD) e_s1++;
    if (res == ST_OUCH) e_s2++;
    push({tag, "_ans"}, res, tgt, DC);
    cyc(1);
    ANS_VALID_1P = 1'b0;
    ANS_VALID_2P = 1'b0;
  endtask

  task automatic hold_result(input string tag, input int res, input int tgt, input int nxt);
    push({tag, "_hold"}, res, tgt, DC);
    cyc(HOLD - 1);
    push({tag, "_exit"}, nxt, 0, DC);
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end

  initial begin
    push("reset", ST_IDLE, 0, 0);
    cyc(2);
    RST = 1'b1;
    push("released", ST_IDLE, 0, 0);
    cyc(0);
    push("enter_wait", ST_WAIT, 0, 0);
    cyc(1);

    // 1P correct, then 2P wrong
    start_round("r1", 5);
    answer("r1", 15, 1'b1, 3, 1'b0, 0, ST_GOOD);
    hold_result("r1", ST_GOOD, 15, ST_WAIT);
    start_round("r2", 10);
    answer("r2", 35, 1'b0, 0, 1'b1, 4, ST_GOOD);
    hold_result("r2", ST_GOOD, 35, ST_WAIT);

    // simultaneous strobes on target 6
    start_round("r3", 1);
    answer("r3", 6, 1'b1, 2, 1'b1, 3, ST_DRAW);
    hold_result("r3", ST_DRAW, 6, ST_WAIT);
    start_round("r4", 1);
    answer("r4", 6, 1'b1, 4, 1'b1, 3, ST_OUCH);
    hold_result("r4", ST_OUCH, 6, ST_WAIT);

    // timeout countdown
    start_round("r5", 2);
    push("r5_t3", ST_Q, 9, 3); cyc(3);
    push("r5_t2", ST_Q, 9, 2); cyc(1);
    push("r5_t1", ST_Q, 9, 1); cyc(4);
    push("r5_t1b", ST_Q, 9, 1); cyc(3);
    push("r5_timeout", ST_DRAW, 9, 0); cyc(1);
    hold_result("r5", ST_DRAW, 9, ST_WAIT);

    // strobe on the timeout cycle wins; third 1P point ends the match
    start_round("r6", 3);
    push("r6_late", ST_Q, 10, 1); cyc(11);
    answer("r6", 10, 1'b1, 5, 1'b0, 0, ST_GOOD);
    hold_result("r6", ST_GOOD, 10, ST_WIN);

    // inputs ignored while the match is over
    OK = 1'b1; NUM = 4'd5;
    ANS_VALID_1P = 1'b1; ANS_1P = 4'd3;
    ANS_VALID_2P = 1'b1; ANS_2P = 4'd1;
    push("win_ignore", ST_WIN, 0, DC);
    cyc(3);
    ANS_VALID_1P = 1'b0; ANS_VALID_2P = 1'b0;
    RESTART = 1'b1;
    e_s1 = 0; e_s2 = 0;
    push("restart", ST_WAIT, 0, DC);
    cyc(1);
    RESTART = 1'b0;

    // OK still high on WAIT entry, then an out-of-range seed
    push("ok_level", ST_WAIT, 0, DC);
    cyc(3);
    OK = 1'b0;
    cyc(1);
    OK = 1'b1; NUM = 4'd12;
    push("bad_num", ST_WAIT, 0, DC);
    cyc(2);
    OK = 1'b0;
    cyc(1);

    // asynchronous reset in the middle of a question
    start_round("r7", 7);
    push("r7_mid", ST_Q, 22, 3);
    cyc(2);
    #2;
    RST = 1'b0;
    #1;
    push("async_rst", ST_IDLE, 0, 0);
    cyc(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
